uart_rx_monitor: RTL and testbench

// - Synthesizable 8N1 UART receiver with an output FIFO. It consumes the serial stream that

---
 rtl/uart_rx_monitor.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver feeding a small byte FIFO.
// It also reports framing errors, FIFO overflow and the end-of-test character.
// Optional build macro UART_PARITY_EN: when defined, the frame is 8E1 and
// parity_err_o is driven. When it is undefined, parity_err_o is tied low.
module uart_rx_monitor #(
  parameter int          CLKS_PER_BIT = 32,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [7:0]  EOT_CHAR     = 8'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  input  logic       rx_en_i,
  input  logic       clr_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overflow_o,
  output logic       eot_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchronizer and edge-detect history. All three flops idle high.
  logic sync1, line, line_q;

  // FSM state
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          push_q;
  logic [7:0]    push_byte;
`ifdef UART_PARITY_EN
  logic          par_bad;
`endif

  // FIFO storage and pointers. The extra MSB on each pointer tells full from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_n, rd_n;
  logic [7:0]  head_n;
  logic        full, pop, do_push;

  // Bring the asynchronous line into the clk domain and keep one cycle of history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      line   <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= rx_i;
      line   <= sync1;
      line_q <= line;
    end
  end

  // Frame FSM. The baud counter restarts on every state entry, so timing tracks the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      push_q       <= 1'b0;
      push_byte    <= '0;
      frame_err_o  <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_o <= 1'b0;
      par_bad      <= 1'b0;
`endif
    end else begin
      push_q       <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      if (!rx_en_i) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (line_q && !line) begin
              state   <= S_START;
              cnt     <= '0;
              bit_cnt <= '0;
`ifdef UART_PARITY_EN
              par_bad <= 1'b0;
`endif
            end
          end
          S_START: begin
            if (cnt == HALF_M1) begin
              cnt   <= '0;
              state <= line ? S_IDLE : S_DATA;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_DATA: begin
            if (cnt == FULL_M1) begin
              cnt     <= '0;
              shreg   <= {line, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`ifdef UART_PARITY_EN
          S_PARITY: begin
            if (cnt == FULL_M1) begin
              cnt   <= '0;
              state <= S_STOP;
              if (line != ^shreg) begin
                parity_err_o <= 1'b1;
                par_bad      <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`endif
          S_STOP: begin
            if (cnt == FULL_M1) begin
              cnt <= '0;
              if (line) begin
                state     <= S_IDLE;
                push_byte <= shreg;
`ifdef UART_PARITY_EN
                push_q    <= !par_bad;
`else
                push_q    <= 1'b1;
`endif
              end else begin
                frame_err_o <= 1'b1;
                state       <= S_BREAK;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_BREAK: begin
            if (line) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifndef UART_PARITY_EN
  assign parity_err_o = 1'b0;
`endif

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = valid_o && ready_i;
  assign do_push = push_q && (!full || pop);

  // Next pointers and next head byte. A push into an empty slot shows the new byte at once.
  always_comb begin
    rd_n = rd_ptr + (AW+1)'(pop);
    wr_n = wr_ptr + (AW+1)'(do_push);
    if (do_push && (rd_n == wr_ptr)) begin
      head_n = push_byte;
    end else begin
      head_n = mem[rd_n[AW-1:0]];
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_byte;
    end
  end

  // FIFO pointers, registered head and valid, and the sticky flags. Set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      overflow_o <= 1'b0;
      eot_o      <= 1'b0;
    end else begin
      wr_ptr  <= wr_n;
      rd_ptr  <= rd_n;
      valid_o <= (wr_n != rd_n);
      if (wr_n != rd_n) begin
        data_o <= head_n;
      end
      if (push_q && full && !pop) begin
        overflow_o <= 1'b1;
      end else if (clr_i) begin
        overflow_o <= 1'b0;
      end
      if (push_q && (push_byte == EOT_CHAR)) begin
        eot_o <= 1'b1;
      end else if (clr_i) begin
        eot_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: serial stimulus into uart_rx_monitor, with a queue-based reference of the bytes expected out.
module tb_uart_rx_monitor;
  localparam int CPB = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic       rx_en_i = 1'b1;
  logic       clr_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, parity_err_o, overflow_o, eot_o;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .EOT_CHAR(8'h04)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .rx_en_i(rx_en_i), .clr_i(clr_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o),
    .overflow_o(overflow_o), .eot_o(eot_o)
  );

  always #5 clk = ~clk;

  // Record every accepted byte and every error pulse
  always @(posedge clk) begin
    if (valid_o && ready_i) got_q.push_back(data_o);
    if (frame_err_o) fe_cnt <= fe_cnt + 1;
    if (parity_err_o) pe_cnt <= pe_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input logic bad_par);
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      tick(CPB);
    end
`ifdef UART_PARITY_EN
    rx_i = (^d) ^ bad_par;
    tick(CPB);
`endif
    rx_i = stop;
    tick(CPB);
  endtask

  task automatic drain(input int want, output bit ok);
    int budget;
    budget = 0;
    ready_i = 1'b1;
    while ((got_q.size() < want || valid_o) && budget < 200) begin
      tick(1);
      budget++;
    end
    ready_i = 1'b0;
    ok = (budget < 200);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data_o); end
    n_checks++; if ({frame_err_o, parity_err_o, overflow_o, eot_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {frame_err_o, parity_err_o, overflow_o, eot_o}); end
    rst_n = 1'b1;
    tick(4);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got=%b exp=0", valid_o); end
  endtask

  task automatic test_basic();
    int base, rise;
    base = got_q.size();
    rise = -1;
    fork
      send_byte(8'h65, 1'b1, 1'b0);
      begin
        for (int t = 1; t <= 400 && rise < 0; t++) begin
          tick(1);
          if (valid_o) rise = t;
        end
      end
    join
    // Start bit is driven at t=0; the stop-bit middle is near t=304, plus sync and push delay
    n_checks++; if (rise < 300 || rise > 312) begin n_fail++; $display("FAIL basic_valid_rise got=%0d exp=300..312", rise); end
    n_checks++; if (data_o !== 8'h65) begin n_fail++; $display("FAIL basic_data got=%h exp=65", data_o); end
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_fall got=%b exp=0", valid_o); end
    n_checks++; if (data_o !== 8'h65) begin n_fail++; $display("FAIL basic_data_hold got=%h exp=65", data_o); end
    n_checks++; if (got_q.size() - base !== 1) begin n_fail++; $display("FAIL basic_pop_count got=%0d exp=1", got_q.size() - base); end
  endtask

  task automatic test_glitch();
    int base, fe0;
    bit ok;
    logic [7:0] v;
    base = got_q.size();
    fe0 = fe_cnt;
    rx_i = 1'b0;
    tick(10);
    rx_i = 1'b1;
    tick(64);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL glitch_no_push got=%b exp=0", valid_o); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_no_ferr got=%0d exp=0", fe_cnt - fe0); end
    send_byte(8'h3C, 1'b1, 1'b0);
    tick(4);
    drain(base + 1, ok);
    v = (got_q.size() > base) ? got_q[base] : 8'hxx;
    n_checks++; if (!ok || got_q.size() - base !== 1 || v !== 8'h3C) begin
      n_fail++; $display("FAIL glitch_next_byte got=%h count=%0d exp=3c count=1", v, got_q.size() - base); end
  endtask

  task automatic test_frame_err();
    int base, fe0;
    bit ok;
    logic [7:0] v;
    base = got_q.size();
    fe0 = fe_cnt;
    send_byte(8'hA5, 1'b0, 1'b0);
    tick(100);
    rx_i = 1'b1;
    tick(2 * CPB);
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - fe0); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL ferr_dropped got=%b exp=0", valid_o); end
    send_byte(8'h3C, 1'b1, 1'b0);
    tick(4);
    drain(base + 1, ok);
    v = (got_q.size() > base) ? got_q[base] : 8'hxx;
    n_checks++; if (!ok || got_q.size() - base !== 1 || v !== 8'h3C) begin
      n_fail++; $display("FAIL ferr_next_byte got=%h count=%0d exp=3c count=1", v, got_q.size() - base); end
  endtask

  task automatic test_overflow();
    int base;
    bit ok;
    logic [7:0] v;
    base = got_q.size();
    ready_i = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1, 1'b0);
    tick(4);
    n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow_o); end
    drain(base + 8, ok);
    n_checks++; if (!ok || got_q.size() - base !== 8) begin
      n_fail++; $display("FAIL ovf_drain_count got=%0d exp=8", got_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      v = (got_q.size() > base + i) ? got_q[base + i] : 8'hxx;
      n_checks++; if (v !== 8'(i)) begin n_fail++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, v, 8'(i)); end
    end
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    tick(1);
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow_o); end
  endtask

  task automatic test_eot();
    int base;
    bit ok;
    base = got_q.size();
    n_checks++; if (eot_o !== 1'b0) begin n_fail++; $display("FAIL eot_before got=%b exp=0", eot_o); end
    send_byte(8'h04, 1'b1, 1'b0);
    tick(2);
    n_checks++; if (eot_o !== 1'b1) begin n_fail++; $display("FAIL eot_set got=%b exp=1", eot_o); end
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    tick(1);
    n_checks++; if (eot_o !== 1'b0) begin n_fail++; $display("FAIL eot_clear got=%b exp=0", eot_o); end
    n_checks++; if (valid_o !== 1'b1 || data_o !== 8'h04) begin
      n_fail++; $display("FAIL eot_in_fifo got=%b/%h exp=1/04", valid_o, data_o); end
    drain(base + 1, ok);
  endtask

  task automatic test_reset_midframe();
    int base, fe0;
    bit ok;
    logic [7:0] v;
    base = got_q.size();
    fe0 = fe_cnt;
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin rx_i = i[0]; tick(CPB); end
    rx_i = 1'b0;
    tick(CPB / 2);
    rst_n = 1'b0;
    rx_i = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2 * CPB);
    n_checks++; if (valid_o !== 1'b0 || fe_cnt - fe0 !== 0) begin
      n_fail++; $display("FAIL midrst_quiet got=%b/%0d exp=0/0", valid_o, fe_cnt - fe0); end
    send_byte(8'h5A, 1'b1, 1'b0);
    tick(4);
    drain(base + 1, ok);
    v = (got_q.size() > base) ? got_q[base] : 8'hxx;
    n_checks++; if (!ok || got_q.size() - base !== 1 || v !== 8'h5A) begin
      n_fail++; $display("FAIL midrst_byte got=%h count=%0d exp=5a count=1", v, got_q.size() - base); end
  endtask

  task automatic test_random();
    int base;
    bit ok, done, exp_eot;
    logic [7:0] v, b;
    base = got_q.size();
    exp_q.delete();
    exp_eot = 1'b0;
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          b = 8'($urandom_range(0, 255));
          exp_q.push_back(b);
          if (b == 8'h04) exp_eot = 1'b1;
          send_byte(b, 1'b1, 1'b0);
          tick($urandom_range(0, 40) + 1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ready_i = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    drain(base + 8, ok);
    n_checks++; if (!ok || got_q.size() - base !== exp_q.size()) begin
      n_fail++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      v = (got_q.size() > base + i) ? got_q[base + i] : 8'hxx;
      n_checks++; if (v !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte idx=%0d got=%h exp=%h", i, v, exp_q[i]); end
    end
    n_checks++; if (eot_o !== exp_eot || overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL rand_flags got=%b/%b exp=%b/0", eot_o, overflow_o, exp_eot); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    int pe0;
    pe0 = pe_cnt;
    send_byte(8'h5A, 1'b1, 1'b1);
    tick(4);
    n_checks++; if (pe_cnt - pe0 !== 1) begin n_fail++; $display("FAIL parity_pulse got=%0d exp=1", pe_cnt - pe0); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL parity_dropped got=%b exp=0", valid_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_eot();
    test_reset_midframe();
    test_random();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
